// File: rtl/dram_axi_mem_rsp_pkg.sv
// Shared constants and types for the DRAM-side AXI4 memory responder.
// Holds the served DRAM window (base address, depth), the AXI channel
// structs used on the responder ports and the responder FSM encoding.
package dram_axi_mem_rsp_pkg;

  localparam int unsigned AxiAddrWidth = 48;
  localparam int unsigned AxiDataWidth = 64;
  localparam int unsigned AxiIdWidth   = 8;
  localparam int unsigned AxiStrbWidth = AxiDataWidth / 8;

  localparam logic [AxiAddrWidth-1:0] DramBaseAddr = 48'h80_0000_0000;
  localparam int unsigned             DramNumWords = 16384;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_WRESP
  } rsp_state_e;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [5:0]              atop;
  } dram_aw_chan_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0] data;
    logic [AxiStrbWidth-1:0] strb;
    logic                    last;
  } dram_w_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } dram_ar_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
  } dram_r_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [1:0]            resp;
  } dram_b_chan_t;

  typedef struct packed {
    dram_aw_chan_t aw;
    logic          aw_valid;
    dram_w_chan_t  w;
    logic          w_valid;
    logic          b_ready;
    dram_ar_chan_t ar;
    logic          ar_valid;
    logic          r_ready;
  } dram_axi_req_t;

  typedef struct packed {
    logic         aw_ready;
    logic         ar_ready;
    logic         w_ready;
    logic         b_valid;
    dram_b_chan_t b;
    logic         r_valid;
    dram_r_chan_t r;
  } dram_axi_rsp_t;

endpackage

// File: rtl/dram_axi_mem_rsp_burst_addr.sv
// Combinational burst address step and DRAM window range check.
//   i_addr/i_len/i_size/i_burst : current beat address and burst attributes
//   o_next_addr                 : address of the following beat
//   o_oob                       : current beat lies outside the served window
module dram_axi_burst_addr
  import dram_axi_mem_rsp_pkg::*;
#(
  parameter int unsigned            AddrWidth = AxiAddrWidth,
  parameter int unsigned            DataWidth = AxiDataWidth,
  parameter int unsigned            NumWords  = DramNumWords,
  parameter logic [AddrWidth-1:0]   BaseAddr  = DramBaseAddr
) (
  input  logic [AddrWidth-1:0] i_addr,
  input  logic [7:0]           i_len,
  input  logic [2:0]           i_size,
  input  logic [1:0]           i_burst,
  output logic [AddrWidth-1:0] o_next_addr,
  output logic                 o_oob
);

  localparam logic [AddrWidth-1:0] EndAddr =
    BaseAddr + AddrWidth'(NumWords * (DataWidth / 8));

  logic [AddrWidth-1:0] w_incr;
  logic [AddrWidth-1:0] w_seq;
  logic [AddrWidth-1:0] w_wrap_mask;

  always_comb begin
    w_incr      = AddrWidth'(1) << i_size;
    w_seq       = i_addr + w_incr;
    // Wrap window is (len+1) beats wide and naturally aligned to its size.
    w_wrap_mask = ((AddrWidth'(i_len) + AddrWidth'(1)) << i_size) - AddrWidth'(1);
    case (i_burst)
      BURST_FIXED: o_next_addr = i_addr;
      BURST_WRAP:  o_next_addr = (i_addr & ~w_wrap_mask) | (w_seq & w_wrap_mask);
      default:     o_next_addr = w_seq;
    endcase
    o_oob = (i_addr < BaseAddr) || (i_addr >= EndAddr);
  end

endmodule

// File: rtl/dram_axi_mem_rsp.sv
// AXI4 memory responder terminating the DRAM serial-link port.
// Serves one burst at a time from a single-port SRAM (1-cycle read latency).
//   clk_i/rst_ni : clock, asynchronous active-low reset
//   axi_req_i    : AW/W/AR channels plus bready/rready
//   axi_rsp_o    : R/B channels plus awready/wready/arready
module dram_axi_mem_rsp
  import dram_axi_mem_rsp_pkg::*;
#(
  parameter int unsigned          AddrWidth = AxiAddrWidth,
  parameter int unsigned          DataWidth = AxiDataWidth,
  parameter int unsigned          IdWidth   = AxiIdWidth,
  parameter int unsigned          NumWords  = DramNumWords,
  parameter logic [AddrWidth-1:0] BaseAddr  = DramBaseAddr,
  parameter type                  axi_req_t = dram_axi_req_t,
  parameter type                  axi_rsp_t = dram_axi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  axi_req_t axi_req_i,
  output axi_rsp_t axi_rsp_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffBits   = $clog2(StrbWidth);
  localparam int unsigned IdxBits   = $clog2(NumWords);

  rsp_state_e           r_state;
  logic                 r_rd_prio;
  logic [IdWidth-1:0]   r_id;
  logic [AddrWidth-1:0] r_addr;
  logic [7:0]           r_len;
  logic [7:0]           r_beat;
  logic [2:0]           r_size;
  logic [1:0]           r_burst;
  logic [5:0]           r_atop;
  logic                 r_issue_done;
  logic                 r_decerr;
  logic                 r_bvalid;
  logic [1:0]           r_bresp;

  logic [DataWidth-1:0] r_mem [NumWords];
  logic [DataWidth-1:0] r_sram_q;
  logic                 r_pipe_vld;
  logic                 r_pipe_oob;
  logic                 r_pipe_last;

  logic [DataWidth-1:0] r_fifo_data [2];
  logic [1:0]           r_fifo_resp [2];
  logic                 r_fifo_last [2];
  logic                 r_wptr;
  logic                 r_rptr;
  logic [1:0]           r_fifo_cnt;

  logic                 w_ar_grant;
  logic                 w_aw_grant;
  logic                 w_r_pop;
  logic [2:0]           w_occ;
  logic                 w_issue;
  logic                 w_w_hs;
  logic                 w_mem_we;
  logic [IdxBits-1:0]   w_idx;
  logic [AddrWidth-1:0] w_next_addr;
  logic                 w_oob;

  dram_axi_burst_addr #(
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth),
    .NumWords  (NumWords),
    .BaseAddr  (BaseAddr)
  ) u_burst_addr (
    .i_addr      (r_addr),
    .i_len       (r_len),
    .i_size      (r_size),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr),
    .o_oob       (w_oob)
  );

  always_comb begin
    w_ar_grant = (r_state == ST_IDLE) && axi_req_i.ar_valid && (!axi_req_i.aw_valid || r_rd_prio);
    w_aw_grant = (r_state == ST_IDLE) && axi_req_i.aw_valid && (!axi_req_i.ar_valid || !r_rd_prio);
    w_r_pop    = (r_fifo_cnt != 2'd0) && axi_req_i.r_ready;
    // Reads already in the SRAM pipeline reserve a FIFO slot; a same-cycle pop frees one.
    w_occ      = {1'b0, r_fifo_cnt} + {2'b0, r_pipe_vld} - {2'b0, w_r_pop};
    w_issue    = (r_state == ST_RD) && !r_issue_done && (w_occ < 3'd2);
    w_w_hs     = (r_state == ST_WR) && axi_req_i.w_valid;
    w_mem_we   = w_w_hs && !w_oob && (r_atop == 6'd0);
    w_idx      = IdxBits'((r_addr - BaseAddr) >> OffBits);
  end

  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      for (int unsigned b = 0; b < StrbWidth; b++) begin
        if (axi_req_i.w.strb[b]) r_mem[w_idx][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
      end
    end
    if (w_issue && !w_oob) r_sram_q <= r_mem[w_idx];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_rd_prio    <= 1'b1;
      r_id         <= '0;
      r_addr       <= '0;
      r_len        <= '0;
      r_beat       <= '0;
      r_size       <= '0;
      r_burst      <= '0;
      r_atop       <= '0;
      r_issue_done <= 1'b0;
      r_decerr     <= 1'b0;
      r_bvalid     <= 1'b0;
      r_bresp      <= RESP_OKAY;
      r_pipe_vld   <= 1'b0;
      r_pipe_oob   <= 1'b0;
      r_pipe_last  <= 1'b0;
      r_wptr       <= 1'b0;
      r_rptr       <= 1'b0;
      r_fifo_cnt   <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_resp[i] <= RESP_OKAY;
        r_fifo_last[i] <= 1'b0;
      end
    end else begin
      r_pipe_vld <= w_issue;
      if (w_issue) begin
        r_pipe_oob  <= w_oob;
        r_pipe_last <= (r_beat == r_len);
      end
      if (r_pipe_vld) begin
        r_fifo_data[r_wptr] <= r_pipe_oob ? '0 : r_sram_q;
        r_fifo_resp[r_wptr] <= r_pipe_oob ? RESP_DECERR : RESP_OKAY;
        r_fifo_last[r_wptr] <= r_pipe_last;
        r_wptr              <= ~r_wptr;
      end
      if (w_r_pop) r_rptr <= ~r_rptr;
      r_fifo_cnt <= r_fifo_cnt + {1'b0, r_pipe_vld} - {1'b0, w_r_pop};

      case (r_state)
        ST_IDLE: begin
          if (w_ar_grant) begin
            r_id         <= axi_req_i.ar.id;
            r_addr       <= axi_req_i.ar.addr;
            r_len        <= axi_req_i.ar.len;
            r_size       <= axi_req_i.ar.size;
            r_burst      <= axi_req_i.ar.burst;
            r_beat       <= '0;
            r_issue_done <= 1'b0;
            r_state      <= ST_RD;
            if (axi_req_i.aw_valid) r_rd_prio <= 1'b0;
          end else if (w_aw_grant) begin
            r_id     <= axi_req_i.aw.id;
            r_addr   <= axi_req_i.aw.addr;
            r_len    <= axi_req_i.aw.len;
            r_size   <= axi_req_i.aw.size;
            r_burst  <= axi_req_i.aw.burst;
            r_atop   <= axi_req_i.aw.atop;
            r_beat   <= '0;
            r_decerr <= 1'b0;
            r_state  <= ST_WR;
            if (axi_req_i.ar_valid) r_rd_prio <= 1'b1;
          end
        end
        ST_RD: begin
          if (w_issue) begin
            r_addr <= w_next_addr;
            if (r_beat == r_len) r_issue_done <= 1'b1;
            else                 r_beat       <= r_beat + 8'd1;
          end
          if (w_r_pop && r_fifo_last[r_rptr]) r_state <= ST_IDLE;
        end
        ST_WR: begin
          if (w_w_hs) begin
            r_addr <= w_next_addr;
            if (w_oob) r_decerr <= 1'b1;
            if (r_beat == r_len) begin
              r_state  <= ST_WRESP;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_atop != 6'd0)      ? RESP_SLVERR :
                          (r_decerr || w_oob)   ? RESP_DECERR : RESP_OKAY;
            end else begin
              r_beat <= r_beat + 8'd1;
            end
          end
        end
        ST_WRESP: begin
          if (axi_req_i.b_ready) begin
            r_bvalid <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = w_aw_grant;
    axi_rsp_o.ar_ready = w_ar_grant;
    axi_rsp_o.w_ready  = (r_state == ST_WR);
    axi_rsp_o.b_valid  = r_bvalid;
    axi_rsp_o.b.id     = r_id;
    axi_rsp_o.b.resp   = r_bresp;
    axi_rsp_o.r_valid  = (r_fifo_cnt != 2'd0);
    axi_rsp_o.r.id     = r_id;
    axi_rsp_o.r.data   = (r_fifo_cnt != 2'd0) ? r_fifo_data[r_rptr] : '0;
    axi_rsp_o.r.resp   = r_fifo_resp[r_rptr];
    axi_rsp_o.r.last   = (r_fifo_cnt != 2'd0) && r_fifo_last[r_rptr];
  end

  // The beat counter decides the end of a write burst; wlast must agree with it.
  a_wlast: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_w_hs |-> (axi_req_i.w.last == (r_beat == r_len)));
  a_atop_no_rresp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_aw_grant |-> !axi_req_i.aw.atop[5]);
  a_wrap_len: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_ar_grant && axi_req_i.ar.burst == BURST_WRAP) |->
      (axi_req_i.ar.len inside {8'd1, 8'd3, 8'd7, 8'd15}));

endmodule

// File: tb/tb_dram_axi_mem_rsp.sv
// Self-checking bench for dram_axi_mem_rsp: a byte-level reference memory
// predicts every R beat and B response; predictions are queued when a
// request is driven and popped by a monitor when the DUT hands them over.
module tb_dram_axi_mem_rsp;
  import dram_axi_mem_rsp_pkg::*;

  localparam logic [47:0] BASE      = 48'h80_0000_0000;
  localparam logic [47:0] MEM_BYTES = 48'd131072;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [7:0]  id;
  } r_exp_t;

  typedef struct {
    logic [1:0] resp;
    logic [7:0] id;
  } b_exp_t;

  logic          clk;
  logic          rst_ni;
  dram_axi_req_t req_drv;
  dram_axi_req_t req;
  dram_axi_rsp_t rsp;
  logic          tb_rready;
  logic          rr_toggle;

  r_exp_t      r_q[$];
  b_exp_t      b_q[$];
  logic [63:0] ref_mem [logic [47:0]];
  int          n_tests;
  int          n_fail;
  int          rx_cnt;
  logic        prev_stall;
  logic [63:0] prev_data;

  dram_axi_mem_rsp #(.NumWords(16384)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .axi_req_i (req),
    .axi_rsp_o (rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req         = req_drv;
    req.r_ready = tb_rready;
  end

  initial begin
    tb_rready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tb_rready = rr_toggle ? ~tb_rready : 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_oob(input logic [47:0] a);
    return (a < BASE) || (a >= BASE + MEM_BYTES);
  endfunction

  function automatic logic [47:0] beat_addr(input logic [47:0] a, input int unsigned len,
                                            input int unsigned size, input logic [1:0] burst,
                                            input int unsigned i);
    longint unsigned aa, sz, win, lo;
    aa  = 64'(a);
    sz  = 64'd1 << size;
    win = 64'(len + 1) * sz;
    case (burst)
      2'b00:   return a;
      2'b10: begin
        lo = aa - (aa % win);
        return 48'(lo + ((aa - lo + 64'(i) * sz) % win));
      end
      default: return 48'(aa + 64'(i) * sz);
    endcase
  endfunction

  function automatic logic [63:0] mem_rd(input logic [47:0] a);
    logic [47:0] k;
    k = a >> 3;
    return ref_mem.exists(k) ? ref_mem[k] : 64'h0;
  endfunction

  // Monitor: sampled on the falling edge, i.e. the values the next rising edge will take.
  always @(negedge clk) begin
    if (!rst_ni) begin
      prev_stall = 1'b0;
      r_q.delete();
    end else begin
      if (prev_stall) begin
        chk("r_hold_valid", 64'(rsp.r_valid), 64'd1);
        chk("r_hold_data", rsp.r.data, prev_data);
      end
      prev_stall = rsp.r_valid && !req.r_ready;
      prev_data  = rsp.r.data;
      if (rsp.r_valid && req.r_ready) begin
        if (r_q.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
        else begin
          r_exp_t e;
          e = r_q.pop_front();
          chk("r_data", rsp.r.data, e.data);
          chk("r_resp", 64'(rsp.r.resp), 64'(e.resp));
          chk("r_last", 64'(rsp.r.last), 64'(e.last));
          chk("r_id", 64'(rsp.r.id), 64'(e.id));
          rx_cnt++;
        end
      end
      if (rsp.b_valid && req.b_ready) begin
        if (b_q.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
        else begin
          b_exp_t e;
          e = b_q.pop_front();
          chk("b_resp", 64'(rsp.b.resp), 64'(e.resp));
          chk("b_id", 64'(rsp.b.id), 64'(e.id));
        end
      end
    end
  end

  task automatic set_ar(input logic [7:0] id, input logic [47:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    req_drv.ar.id    = id;
    req_drv.ar.addr  = addr;
    req_drv.ar.len   = len;
    req_drv.ar.size  = size;
    req_drv.ar.burst = burst;
    req_drv.ar_valid = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      r_exp_t e;
      logic [47:0] a;
      a      = beat_addr(addr, len, size, burst, i);
      e.data = is_oob(a) ? 64'h0 : mem_rd(a);
      e.resp = is_oob(a) ? RESP_DECERR : RESP_OKAY;
      e.last = (i == int'(len));
      e.id   = id;
      r_q.push_back(e);
    end
  endtask

  task automatic set_aw(input logic [7:0] id, input logic [47:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [5:0] atop);
    req_drv.aw.id    = id;
    req_drv.aw.addr  = addr;
    req_drv.aw.len   = len;
    req_drv.aw.size  = 3'd3;
    req_drv.aw.burst = burst;
    req_drv.aw.atop  = atop;
    req_drv.aw_valid = 1'b1;
  endtask

  task automatic read_burst(input logic [7:0] id, input logic [47:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    int cyc;
    set_ar(id, addr, len, size, burst);
    cyc = 0;
    @(negedge clk);
    while (!rsp.ar_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) chk("ar_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    req_drv.ar_valid = 1'b0;
  endtask

  // Drives the W beats of an already accepted AW; data of beat i is data_base+i.
  task automatic write_beats(input logic [7:0] id, input logic [47:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [5:0] atop,
                             input logic [63:0] data_base, input logic [7:0] strb);
    b_exp_t be;
    logic   any_oob;
    int     cyc;
    any_oob = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      logic [47:0] a;
      logic [63:0] d, w;
      a = beat_addr(addr, len, 3, burst, i);
      d = data_base + 64'(i);
      if (is_oob(a)) any_oob = 1'b1;
      else if (atop == 6'd0) begin
        w = mem_rd(a);
        for (int b = 0; b < 8; b++) if (strb[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[a >> 3] = w;
      end
      req_drv.w.data  = d;
      req_drv.w.strb  = strb;
      req_drv.w.last  = (i == int'(len));
      req_drv.w_valid = 1'b1;
      cyc = 0;
      @(negedge clk);
      while (!rsp.w_ready && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      if (cyc >= 100) chk("w_timeout", 64'd0, 64'd1);
      if (i == int'(len)) begin
        be.resp = (atop != 6'd0) ? RESP_SLVERR : any_oob ? RESP_DECERR : RESP_OKAY;
        be.id   = id;
        b_q.push_back(be);
      end
      @(posedge clk);
      #1;
    end
    req_drv.w_valid = 1'b0;
    req_drv.w.last  = 1'b0;
    @(negedge clk);
    chk("b_latency", 64'(rsp.b_valid), 64'd1);
  endtask

  task automatic write_burst(input logic [7:0] id, input logic [47:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [5:0] atop,
                             input logic [63:0] data_base, input logic [7:0] strb);
    int cyc;
    set_aw(id, addr, len, burst, atop);
    cyc = 0;
    @(negedge clk);
    while (!rsp.aw_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) chk("aw_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    req_drv.aw_valid = 1'b0;
    write_beats(id, addr, len, burst, atop, data_base, strb);
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while ((r_q.size() != 0 || b_q.size() != 0) && cyc < 1000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 1000) chk("drain_timeout", 64'(r_q.size() + b_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    n_tests   = 0;
    n_fail    = 0;
    rx_cnt    = 0;
    rr_toggle = 1'b0;
    req_drv   = '0;
    req_drv.b_ready = 1'b1;
    rst_ni    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", 64'(rsp.r_valid), 64'd0);
    chk("rst_bvalid", 64'(rsp.b_valid), 64'd0);
    chk("rst_wready", 64'(rsp.w_ready), 64'd0);
    chk("rst_rdata", rsp.r.data, 64'd0);
    chk("rst_bresp", 64'(rsp.b.resp), 64'(RESP_OKAY));
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Arbitration: contention twice in a row -> read first, then write.
    set_ar(8'h11, BASE - 48'd8, 8'd0, 3'd3, BURST_INCR);
    set_aw(8'h22, BASE + 48'h80, 8'd0, BURST_INCR, 6'd0);
    @(negedge clk);
    chk("arb1_arready", 64'(rsp.ar_ready), 64'd1);
    chk("arb1_awready", 64'(rsp.aw_ready), 64'd0);
    @(posedge clk);
    #1;
    req_drv.ar_valid = 1'b0;
    req_drv.aw_valid = 1'b0;
    wait_drain();
    req_drv.ar_valid = 1'b1;
    req_drv.aw_valid = 1'b1;
    @(negedge clk);
    chk("arb2_arready", 64'(rsp.ar_ready), 64'd0);
    chk("arb2_awready", 64'(rsp.aw_ready), 64'd1);
    @(posedge clk);
    #1;
    req_drv.ar_valid = 1'b0;
    req_drv.aw_valid = 1'b0;
    write_beats(8'h22, BASE + 48'h80, 8'd0, BURST_INCR, 6'd0, 64'h1234, 8'hFF);
    wait_drain();

    // Single write then read, with first-beat latency.
    write_burst(8'h01, BASE + 48'h40, 8'd0, BURST_INCR, 6'd0, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    wait_drain();
    read_burst(8'h02, BASE + 48'h40, 8'd0, 3'd3, BURST_INCR);
    lat = 0;
    @(negedge clk);
    while (!rsp.r_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("r_first_latency", 64'(lat), 64'd2);
    wait_drain();

    // INCR len=7 with rready toggling.
    write_burst(8'h03, BASE + 48'h400, 8'd7, BURST_INCR, 6'd0, 64'hA000_0000_0000_0100, 8'hFF);
    wait_drain();
    rr_toggle = 1'b1;
    rx_cnt    = 0;
    read_burst(8'h5A, BASE + 48'h400, 8'd7, 3'd3, BURST_INCR);
    wait_drain();
    rr_toggle = 1'b0;
    chk("incr_beats", 64'(rx_cnt), 64'd8);

    // WRAP len=3 starting at word 2 -> words 2,3,0,1.
    write_burst(8'h04, BASE, 8'd3, BURST_INCR, 6'd0, 64'h5555_0000_0000_0000, 8'hFF);
    wait_drain();
    read_burst(8'h05, BASE + 48'h10, 8'd3, 3'd3, BURST_WRAP);
    wait_drain();

    // Strobes: only the low four bytes are overwritten.
    write_burst(8'h06, BASE + 48'h200, 8'd0, BURST_INCR, 6'd0, 64'h1111_2222_3333_4444, 8'hFF);
    write_burst(8'h06, BASE + 48'h200, 8'd0, BURST_INCR, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    wait_drain();
    read_burst(8'h07, BASE + 48'h200, 8'd0, 3'd3, BURST_INCR);
    wait_drain();

    // Below-window FIXED read -> two zero beats with DECERR.
    read_burst(8'h08, BASE - 48'd8, 8'd1, 3'd3, BURST_FIXED);
    wait_drain();

    // Atomic store (no R response): SLVERR and memory untouched.
    write_burst(8'h09, BASE + 48'h40, 8'd0, BURST_INCR, 6'h11, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF);
    wait_drain();
    read_burst(8'h0A, BASE + 48'h40, 8'd0, 3'd3, BURST_INCR);
    wait_drain();

    // Window edges: last word is served, one past the end is DECERR.
    write_burst(8'h0B, BASE + MEM_BYTES - 48'd8, 8'd0, BURST_INCR, 6'd0, 64'h7777_8888_9999_AAAA, 8'hFF);
    write_burst(8'h0C, BASE + MEM_BYTES, 8'd0, BURST_INCR, 6'd0, 64'h1, 8'hFF);
    wait_drain();
    read_burst(8'h0D, BASE + MEM_BYTES - 48'd8, 8'd1, 3'd3, BURST_INCR);
    wait_drain();

    // len=255 write/read round trip over 256 words.
    write_burst(8'h0E, BASE + 48'h1000, 8'd255, BURST_INCR, 6'd0, 64'hC0DE_0000_0000_0000, 8'hFF);
    wait_drain();
    rx_cnt = 0;
    read_burst(8'h0F, BASE + 48'h1000, 8'd255, 3'd3, BURST_INCR);
    wait_drain();
    chk("len255_beats", 64'(rx_cnt), 64'd256);

    // Reset in the middle of a len=7 read, then a clean read.
    rx_cnt = 0;
    read_burst(8'h10, BASE + 48'h400, 8'd7, 3'd3, BURST_INCR);
    lat = 0;
    while (rx_cnt < 3 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) chk("midburst_timeout", 64'(rx_cnt), 64'd3);
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_rvalid", 64'(rsp.r_valid), 64'd0);
    chk("rst_mid_bvalid", 64'(rsp.b_valid), 64'd0);
    chk("rst_mid_wready", 64'(rsp.w_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    rx_cnt = 0;
    read_burst(8'h11, BASE + 48'h400, 8'd7, 3'd3, BURST_INCR);
    wait_drain();
    chk("post_rst_beats", 64'(rx_cnt), 64'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
